// File: rtl/layer_sequencer_if.sv
// Handshake and neuron broadcast bundle for layer_sequencer.
// master = sequencer side, slave = environment side.
interface layer_sequencer_if #(
    parameter int NUM_NEURON = 30,
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0]            in_data;
    logic                             in_valid;
    logic                             in_ready;
    logic                             neuron_freeze;
    logic [DATA_WIDTH-1:0]            neuron_in;
    logic [NUM_NEURON*DATA_WIDTH-1:0] neuron_out;
    logic [NUM_NEURON*DATA_WIDTH-1:0] out_data;
    logic                             out_valid;
    logic                             out_ready;
    logic                             busy;
    logic [15:0]                      vec_count;

    modport master (
        input  in_data, in_valid, neuron_out, out_ready,
        output in_ready, neuron_freeze, neuron_in,
        output out_data, out_valid, busy, vec_count
    );

    modport slave (
        output in_data, in_valid, neuron_out, out_ready,
        input  in_ready, neuron_freeze, neuron_in,
        input  out_data, out_valid, busy, vec_count
    );
endinterface

// File: rtl/layer_sequencer.sv
// layer_sequencer: buffers one activation vector and steps a shared-input layer.
// Optional LAYER_SEQ_PINGPONG_EN adds a second bank so loading overlaps compute.
module layer_sequencer #(
    parameter int NUM_WEIGHT = 784,
    parameter int NUM_NEURON = 30,
    parameter int DATA_WIDTH = 16
) (
    input logic               clk,
    input logic               rst,
    layer_sequencer_if.master bus
);
    localparam int PW = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
    localparam int OW = NUM_NEURON * DATA_WIDTH;
    localparam logic [PW-1:0] LAST = PW'(NUM_WEIGHT - 1);

    typedef enum logic [1:0] {LOAD, RUN, SETTLE, OUTPUT} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic                  freeze_q;
    logic                  out_valid_q;
    logic [OW-1:0]         out_data_q;
    logic [15:0]           vec_cnt_q;
    logic                  accept, fill, xfer;
    logic                  pend, in_rdy;
    logic [DATA_WIDTH-1:0] rd_word;

    assign accept = bus.in_valid & in_rdy;
    assign fill   = accept & (wr_ptr_q == LAST);
    assign xfer   = out_valid_q & bus.out_ready;

`ifdef LAYER_SEQ_PINGPONG_EN
    logic [DATA_WIDTH-1:0] mem [2][NUM_WEIGHT];
    logic                  ld_q, rn_q;
    logic [1:0]            full_q;
    logic                  swap;

    assign in_rdy = ~rst & ~full_q[ld_q];
    // pend: a complete vector is ready to run without a LOAD phase
    assign pend   = full_q[ld_q] | fill;
    assign swap   = (fill & (state_q == LOAD)) | (xfer & pend);

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_q   <= 1'b0;
            rn_q   <= 1'b0;
            full_q <= '0;
        end else if (swap) begin
            rn_q         <= ld_q;
            ld_q         <= ~ld_q;
            full_q[ld_q] <= 1'b0;
        end else if (fill) begin
            full_q[ld_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[ld_q][wr_ptr_q] <= bus.in_data;
    end

    assign rd_word  = mem[rn_q][rd_ptr_q];
    assign bus.busy = (state_q != LOAD) | (wr_ptr_q != '0)
                    | (|full_q);
`else
    logic [DATA_WIDTH-1:0] mem [NUM_WEIGHT];

    assign in_rdy = ~rst & (state_q == LOAD);
    assign pend   = 1'b0;

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr_q] <= bus.in_data;
    end

    assign rd_word  = mem[rd_ptr_q];
    assign bus.busy = (state_q != LOAD) | (wr_ptr_q != '0);
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (fill) state_d = RUN;
            RUN:     if (rd_ptr_q == LAST) state_d = SETTLE;
            SETTLE:  state_d = OUTPUT;
            OUTPUT:  if (xfer) state_d = pend ? RUN : LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            freeze_q    <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            vec_cnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            // freeze is registered off next state so RUN spans NUM_WEIGHT edges
            freeze_q <= (state_d != RUN);
            if (accept)
                wr_ptr_q <= fill ? '0 : wr_ptr_q + 1'b1;
            if ((state_q == RUN) && (rd_ptr_q != LAST))
                rd_ptr_q <= rd_ptr_q + 1'b1;
            else
                rd_ptr_q <= '0;
            if (state_q == SETTLE) begin
                out_data_q  <= bus.neuron_out;
                out_valid_q <= 1'b1;
            end else if (xfer) begin
                out_valid_q <= 1'b0;
                vec_cnt_q   <= vec_cnt_q + 1'b1;
            end
        end
    end

    assign bus.in_ready      = in_rdy;
    assign bus.neuron_freeze = freeze_q;
    assign bus.neuron_in     = (state_q == RUN) ? rd_word : '0;
    assign bus.out_data      = out_data_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.vec_count     = vec_cnt_q;
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: scoreboard bench with a 2-neuron accumulate model.
// Neuron i weight for word k is k+1+i; results below are hand-computed.
`timescale 1ns/1ps
module tb_layer_sequencer;
    localparam int NW = 4;
    localparam int NN = 2;
    localparam int DW = 16;
`ifdef LAYER_SEQ_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    localparam logic [63:0] VA = 64'h0800_1000_0000_F800;
    localparam logic [31:0] RA = 32'h1800_0800;
    localparam logic [63:0] VB = 64'h0001_0002_0003_0004;
    localparam logic [31:0] RB = 32'h0028_001E;
    localparam logic [63:0] VC = 64'h0100_0000_0000_0000;
    localparam logic [31:0] RC = 32'h0200_0100;
    localparam logic [63:0] VD = 64'h0000_0000_0000_0010;
    localparam logic [31:0] RD = 32'h0050_0040;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    layer_sequencer_if #(.NUM_NEURON(NN), .DATA_WIDTH(DW)) bus ();

    layer_sequencer #(
        .NUM_WEIGHT(NW),
        .NUM_NEURON(NN),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    logic [15:0] run_q [$];
    logic [31:0] out_q [$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // neuron model: restarts its sum on the first unfrozen cycle
    logic [15:0] acc [NN] = '{16'h0, 16'h0};
    int          k_cnt = 0;
    logic        prev_frz = 1'b1;
    always @(posedge clk) begin
        prev_frz <= bus.neuron_freeze;
        if (bus.neuron_freeze) begin
            k_cnt <= 0;
        end else begin
            k_cnt <= k_cnt + 1;
            for (int i = 0; i < NN; i++)
                acc[i] <= (prev_frz ? 16'h0 : acc[i])
                        + 16'(bus.neuron_in * 16'(k_cnt + 1 + i));
        end
    end
    assign bus.neuron_out = {acc[1], acc[0]};

    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.neuron_freeze) begin
                check("run_word_expected", 32'(run_q.size() != 0), 1);
                if (run_q.size() != 0)
                    check("neuron_in", 32'(bus.neuron_in),
                          32'(run_q.pop_front()));
            end
            if (bus.out_valid) begin
                check("freeze_while_valid", 32'(bus.neuron_freeze), 1);
                if (bus.out_ready) begin
                    check("result_expected", 32'(out_q.size() != 0), 1);
                    if (out_q.size() != 0)
                        check("out_data", bus.out_data, out_q.pop_front());
                end
            end
        end
    end

    task automatic push_word(input logic [15:0] w);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        @(negedge clk);
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("in_handshake", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_vec(input logic [63:0] v, input logic [31:0] exp,
                            input bit bubble);
        @(posedge clk); #1;
        for (int k = 0; k < NW; k++) run_q.push_back(v[63-16*k -: 16]);
        out_q.push_back(exp);
        for (int k = 0; k < NW; k++) begin
            push_word(v[63-16*k -: 16]);
            if (bubble && k != NW - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic take_result(input int hold, input logic [31:0] exp,
                               input logic [15:0] cnt, input bit wrap);
        int t = 0;
        @(negedge clk);
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("out_valid_seen", 32'(bus.out_valid), 1);
        for (int i = 0; i < hold; i++) begin
            check("held_data", bus.out_data, exp);
            check("held_freeze", 32'(bus.neuron_freeze), 1);
            check("held_valid", 32'(bus.out_valid), 1);
            @(negedge clk);
        end
        if (wrap) begin
            force dut.vec_cnt_q = 16'hFFFF;
            #1 release dut.vec_cnt_q;
            check("vec_forced", 32'(bus.vec_count), 32'hFFFF);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("valid_cleared", 32'(bus.out_valid), 0);
        check("vec_count", 32'(bus.vec_count), 32'(cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: no finish after %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_freeze", 32'(bus.neuron_freeze), 1);
        check("rst_neuron_in", 32'(bus.neuron_in), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_vec_count", 32'(bus.vec_count), 0);
        check("rst_busy", 32'(bus.busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("load_in_ready", 32'(bus.in_ready), 1);

        send_vec(VA, RA, 1'b0);
        @(negedge clk);
        check("in_ready_drop", 32'(bus.in_ready), 32'(PP));
        check("run_start", 32'(bus.neuron_freeze), 0);
        n = 1;
        @(negedge clk);
        while (!bus.neuron_freeze && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("run_len", 32'(n), 4);
        check("settle_no_valid", 32'(bus.out_valid), 0);
        check("settle_neuron_in", 32'(bus.neuron_in), 0);
        @(negedge clk);
        check("valid_rise", 32'(bus.out_valid), 1);
        take_result(0, RA, 16'd1, 1'b0);

        send_vec(VB, RB, 1'b1);
        @(negedge clk);
        check("bubble_run_start", 32'(bus.neuron_freeze), 0);
        check("bubble_in_ready", 32'(bus.in_ready), 32'(PP));
        take_result(0, RB, 16'd2, 1'b0);

        send_vec(VC, RC, 1'b0);
        take_result(10, RC, 16'd3, 1'b0);

        send_vec(VD, RD, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_cycle_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_q.delete();
        out_q.delete();
        @(negedge clk);
        check("midrun_freeze", 32'(bus.neuron_freeze), 1);
        check("midrun_out_valid", 32'(bus.out_valid), 0);
        check("midrun_in_ready", 32'(bus.in_ready), 1);
        check("midrun_busy", 32'(bus.busy), 0);
        check("midrun_vec_count", 32'(bus.vec_count), 0);
        send_vec(VA, RA, 1'b0);
        take_result(0, RA, 16'd1, 1'b0);

        send_vec(VB, RB, 1'b0);
        take_result(2, RB, 16'd0, 1'b1);

`ifdef LAYER_SEQ_PINGPONG_EN
        bus.out_ready = 1'b1;
        fork
            begin
                send_vec(VA, RA, 1'b0);
                send_vec(VB, RB, 1'b0);
                send_vec(VC, RC, 1'b0);
            end
        join_none
        n = 0;
        while ((out_q.size() != 0 || n < 3) && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("pp_fast", 32'(n <= 25), 1);
        check("pp_vec_count", 32'(bus.vec_count), 3);
`endif

        repeat (3) @(negedge clk);
        check("run_q_drained", 32'(run_q.size()), 0);
        check("out_q_drained", 32'(out_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
